// File: rtl/top_module_sdiv_25s_6ns_25_seq.sv
// top_module_sdiv_25s_6ns_25_seq: sequential 25-bit signed / 6-bit unsigned restoring divider
module top_module_sdiv_25s_6ns_25_seq #(
  parameter ID = 32'd1,
  parameter din0_WIDTH = 32'd25,
  parameter din1_WIDTH = 32'd6,
  parameter dout_WIDTH = 32'd25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ready,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [6:0]            rem,
  output logic                  div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
  state_t state, nxt;
  logic [24:0] mag;
  logic [5:0] pr, dv;
  logic neg, ge, zero;
  logic [4:0] cnt;
  logic [6:0] trial, diff;
  logic unused_id;
  assign unused_id = ^ID;
  always_comb begin
    trial = {pr, mag[24]};
    diff = trial - {1'b0, dv};
    ge = trial >= {1'b0, dv};
    zero = dv == 6'd0;
    ready = state == IDLE;
    done = state == DONE;
    nxt = state == IDLE ? (start ? CALC : IDLE) :
          state == CALC ? (cnt == 5'd24 ? SIGN : CALC) :
          state == SIGN ? DONE : IDLE;
  end
  // magnitude register doubles as the quotient shift register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      mag <= '0;
      pr <= '0;
      dv <= '0;
      neg <= 1'b0;
      cnt <= '0;
      dout <= '0;
      rem <= '0;
      div_by_zero <= 1'b0;
    end else if (ce) begin
      state <= nxt;
      if (state == IDLE && start) begin
        mag <= din0[24] ? -din0 : din0;
        pr <= '0;
        cnt <= '0;
        dv <= din1;
        neg <= din0[24];
      end
      if (state == CALC) begin
        pr <= ge ? diff[5:0] : trial[5:0];
        mag <= {mag[23:0], ge};
        cnt <= cnt + 5'd1;
      end
      if (state == SIGN) begin
        dout <= zero ? '1 : neg ? -mag : mag;
        rem <= zero ? '0 : neg ? -{1'b0, pr} : {1'b0, pr};
        div_by_zero <= zero;
      end
    end
  end
endmodule

// File: tb/tb_top_module_sdiv_25s_6ns_25_seq.sv
// tb_top_module_sdiv_25s_6ns_25_seq: vector table, random ops against an arithmetic model, and corner sequences
module tb_top_module_sdiv_25s_6ns_25_seq;
  logic clk = 1'b0, reset = 1'b0, ce = 1'b1, start = 1'b0;
  logic [24:0] din0 = '0;
  logic [5:0] din1 = '0;
  logic ready, done, div_by_zero;
  logic [24:0] dout;
  logic [6:0] rem;
  int checks = 0, failures = 0;

  top_module_sdiv_25s_6ns_25_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .din0(din0), .din1(din1),
    .ready(ready), .done(done), .dout(dout), .rem(rem), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {int a; int b; int q; int r; int z;} vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic wait_done(input int stall_at, input bit scramble, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (n == stall_at) ce = 1'b0;
      if (n == stall_at + 10) ce = 1'b1;
      if (n == 3 || n == 6) start = 1'b0;
      if (scramble && n == 5) begin
        din0 = 25'($urandom);
        din1 = 6'($urandom);
        start = 1'b1;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    ce = 1'b1;
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat, input int q, input int r, input int z);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_dout"}, int'($signed(dout)), q);
    chk({tag, "_rem"}, int'($signed(rem)), r);
    chk({tag, "_dbz"}, int'(div_by_zero), z);
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int q, input int r, input int z,
                        input int exp_lat, input int stall_at, input bit scramble);
    int lat;
    @(negedge clk);
    din0 = 25'(a);
    din1 = 6'(b);
    start = 1'b1;
    ce = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy"}, int'(ready), 0);
    wait_done(stall_at, scramble, lat);
    check_result(tag, lat, exp_lat, q, r, z);
    @(posedge clk); #1;
    chk({tag, "_pulse_done"}, int'(done), 0);
    chk({tag, "_pulse_ready"}, int'(ready), 1);
  endtask

  initial begin
    int a, b, q, r, z, lat, cnt;
    logic [24:0] v;
    tbl[0] = '{100, 7, 14, 2, 0};
    tbl[1] = '{-100, 7, -14, -2, 0};
    tbl[2] = '{-16777216, 1, -16777216, 0, 0};
    tbl[3] = '{16777215, 63, 266305, 0, 0};
    tbl[4] = '{5, 63, 0, 5, 0};
    tbl[5] = '{1234, 0, -1, 0, 1};
    tbl[6] = '{-16777216, 63, -266305, -1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    reset = 1'b1;

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, 26, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      v = 25'($urandom);
      a = int'($signed(v));
      b = (i % 10 == 9) ? 0 : $urandom_range(0, 63);
      if (b == 0) begin q = -1; r = 0; z = 1; end
      else begin q = a / b; r = a % b; z = 0; end
      run_op($sformatf("rnd%0d", i), a, b, q, r, z, 26, 0, 1'b0);
    end

    run_op("stall", 100, 7, 14, 2, 0, 36, 8, 1'b1);

    @(negedge clk);
    din0 = 25'd200;
    din1 = 6'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 1'b0, lat);
    check_result("b2b_first", lat, 26, 22, 2, 0);
    din0 = 25'(-50);
    din1 = 6'd6;
    start = 1'b1;
    wait_done(0, 1'b0, lat);
    check_result("b2b_second", lat, 28, -8, -2, 0);
    @(posedge clk); #1;

    @(negedge clk);
    din0 = 25'd4321;
    din1 = 6'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ce = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", int'(ready), 1);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_rem", int'(rem), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    reset = 1'b1;
    ce = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    run_op("after_rst", 100, 7, 14, 2, 0, 26, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
